// File: rtl/genesys_pkg.sv
// Shared definitions for the genesys accumulation datapath.
// Widths that depend on a block's own parameters are derived here.
package genesys_pkg;

  localparam int NUM_REQ_MAX = 8;

  // Requester index width. It is never narrower than one bit, so a two-client
  // arbiter still carries a real index.
  function automatic int req_id_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  localparam int REQ_ID_W_MAX = req_id_w(NUM_REQ_MAX);

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker. It grants the first set request at or after
// ptr, searching modulo NUM_REQ.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = genesys_pkg::req_id_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_id
);

  logic            found;
  logic [ID_W-1:0] idx;

  always_comb begin
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    idx      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = ID_W'((int'(ptr) + k) % NUM_REQ);
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_id   = idx;
      end
    end
  end

endmodule

// File: rtl/signed_adder.sv
// Fixed-point signed adder. Both operands are sign-extended to the output width.
// The sum wraps modulo 2**OUT_WIDTH.
module signed_adder #(
  parameter string DTYPE           = "FXP",
  parameter string REGISTER_OUTPUT = "FALSE",
  parameter int    IN1_WIDTH       = 20,
  parameter int    IN2_WIDTH       = 32,
  parameter int    OUT_WIDTH       = 32
) (
  input  logic signed [IN1_WIDTH-1:0] a,
  input  logic signed [IN2_WIDTH-1:0] b,
  output logic signed [OUT_WIDTH-1:0] out
);

  // Only the combinational fixed-point flavour exists in this codebase.
  localparam bit SUPPORTED = (DTYPE == "FXP") && (REGISTER_OUTPUT == "FALSE");

  function automatic logic signed [OUT_WIDTH-1:0] sext_a(input logic signed [IN1_WIDTH-1:0] v);
    return OUT_WIDTH'(v);
  endfunction

  function automatic logic signed [OUT_WIDTH-1:0] sext_b(input logic signed [IN2_WIDTH-1:0] v);
    return OUT_WIDTH'(v);
  endfunction

  function automatic logic signed [OUT_WIDTH-1:0] wrap_add(input logic signed [OUT_WIDTH-1:0] x,
                                                          input logic signed [OUT_WIDTH-1:0] y);
    return x + y;
  endfunction

  assign out = SUPPORTED ? wrap_add(sext_a(a), sext_b(b)) : '0;

endmodule

// File: rtl/signed_adder_arbiter.sv
// Round-robin front end that shares one signed adder among NUM_REQ clients.
// Each sum returns after ADD_LATENCY enabled cycles, tagged with a one-hot strobe.
module signed_adder_arbiter
  import genesys_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int IN1_WIDTH   = 20,
  parameter int IN2_WIDTH   = 32,
  parameter int OUT_WIDTH   = 32,
  parameter int ADD_LATENCY = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           enable,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ*IN1_WIDTH-1:0]   req_a,
  input  logic [NUM_REQ*IN2_WIDTH-1:0]   req_b,
  output logic [NUM_REQ-1:0]             rsp_valid,
  output logic [OUT_WIDTH-1:0]           rsp_data,
  output logic                           busy
);

  localparam int REQ_ID_W = req_id_w(NUM_REQ);

  typedef struct packed {
    logic                        valid;
    logic [REQ_ID_W-1:0]         id;
    logic signed [OUT_WIDTH-1:0] data;
  } stage_t;

  logic [REQ_ID_W-1:0]         ptr;
  logic [REQ_ID_W-1:0]         ptr_next;
  logic [REQ_ID_W-1:0]         grant_id;
  logic [NUM_REQ-1:0]          grant;
  logic [NUM_REQ-1:0]          pick_req;
  logic                        xfer;
  logic signed [IN1_WIDTH-1:0] sel_a;
  logic signed [IN2_WIDTH-1:0] sel_b;
  logic signed [OUT_WIDTH-1:0] sum;
  stage_t                      pipe [ADD_LATENCY];
  stage_t                      last;

  // Grant: stalls are applied by hiding all requests from the picker.
  assign pick_req = enable ? req_valid : '0;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (REQ_ID_W)
  ) u_rr_pick (
    .req      (pick_req),
    .ptr      (ptr),
    .grant    (grant),
    .grant_id (grant_id)
  );

  assign req_ready = grant;
  assign xfer      = |(req_valid & grant);
  assign ptr_next  = (grant_id == REQ_ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr <= '0;
    end else if (xfer) begin
      ptr <= ptr_next;
    end
  end

  assign sel_a = req_a[grant_id*IN1_WIDTH +: IN1_WIDTH];
  assign sel_b = req_b[grant_id*IN2_WIDTH +: IN2_WIDTH];

  signed_adder #(
    .DTYPE           ("FXP"),
    .REGISTER_OUTPUT ("FALSE"),
    .IN1_WIDTH       (IN1_WIDTH),
    .IN2_WIDTH       (IN2_WIDTH),
    .OUT_WIDTH       (OUT_WIDTH)
  ) u_signed_adder (
    .a   (sel_a),
    .b   (sel_b),
    .out (sum)
  );

  // Stage 0 captures the sum. Later stages shift. Every stage freezes while enable is low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < ADD_LATENCY; k++) pipe[k] <= '0;
    end else if (enable) begin
      pipe[0] <= '{valid: xfer, id: grant_id, data: sum};
      for (int k = 1; k < ADD_LATENCY; k++) pipe[k] <= pipe[k-1];
    end
  end

  // Response: the strobe is masked during a stall, so the held result is delivered once.
  assign last     = pipe[ADD_LATENCY-1];
  assign rsp_data = last.data;

  always_comb begin
    rsp_valid = '0;
    if (last.valid && enable) rsp_valid[last.id] = 1'b1;
  end

  always_comb begin
    busy = 1'b0;
    for (int k = 0; k < ADD_LATENCY; k++) busy = busy | pipe[k].valid;
  end

endmodule

// File: tb/tb_signed_adder_arbiter.sv
// Directed bench for signed_adder_arbiter with hand-computed grants and sums.
module tb_signed_adder_arbiter;

  localparam int NUM_REQ     = 4;
  localparam int IN1_WIDTH   = 20;
  localparam int IN2_WIDTH   = 32;
  localparam int OUT_WIDTH   = 32;
  localparam int ADD_LATENCY = 2;

  logic                         clk = 1'b0;
  logic                         reset;
  logic                         enable;
  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ-1:0]           req_ready;
  logic [NUM_REQ*IN1_WIDTH-1:0] req_a;
  logic [NUM_REQ*IN2_WIDTH-1:0] req_b;
  logic [NUM_REQ-1:0]           rsp_valid;
  logic [OUT_WIDTH-1:0]         rsp_data;
  logic                         busy;

  logic signed [IN1_WIDTH-1:0]  op_a [NUM_REQ];
  logic signed [IN2_WIDTH-1:0]  op_b [NUM_REQ];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      req_a[i*IN1_WIDTH +: IN1_WIDTH] = op_a[i];
      req_b[i*IN2_WIDTH +: IN2_WIDTH] = op_b[i];
    end
  end

  signed_adder_arbiter #(
    .NUM_REQ     (NUM_REQ),
    .IN1_WIDTH   (IN1_WIDTH),
    .IN2_WIDTH   (IN2_WIDTH),
    .OUT_WIDTH   (OUT_WIDTH),
    .ADD_LATENCY (ADD_LATENCY)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [1:0] i, input logic signed [19:0] a, input logic signed [31:0] b);
    op_a[i] = a;
    op_b[i] = b;
  endtask

  // Checks the outputs at the falling edge of the current cycle.
  task automatic sample(input string tag, input logic [3:0] ready_e, input logic [3:0] rsp_e,
                        input logic [31:0] data_e, input logic busy_e);
    @(negedge clk);
    check({tag, ".ready"}, 32'(req_ready), 32'(ready_e));
    check({tag, ".rsp_valid"}, 32'(rsp_valid), 32'(rsp_e));
    if (rsp_e != 4'b0000) check({tag, ".rsp_data"}, rsp_data, data_e);
    check({tag, ".busy"}, 32'(busy), 32'(busy_e));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  er;
    logic [3:0]  ev;
    logic [31:0] ed;

    reset     = 1'b1;
    enable    = 1'b1;
    req_valid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      op_a[i] = '0;
      op_b[i] = '0;
    end

    // Reset state
    #2;
    sample("reset", 4'b0000, 4'b0000, 32'h0, 1'b0);
    check("reset.rsp_data", rsp_data, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Single request from requester 2: 5 + -7
    set_op(2'd2, 20'sd5, -32'sd7);
    req_valid = 4'b0100;
    sample("single.c0", 4'b0100, 4'b0000, 32'h0, 1'b0);
    next_cycle();
    req_valid = 4'b0000;
    sample("single.c1", 4'b0000, 4'b0000, 32'h0, 1'b1);
    next_cycle();
    sample("single.c2", 4'b0000, 4'b0100, 32'hFFFF_FFFE, 1'b1);
    next_cycle();
    sample("single.c3", 4'b0000, 4'b0000, 32'h0, 1'b0);

    // All four requesters continuously valid from reset
    reset = 1'b1;
    #2;
    reset = 1'b0;
    next_cycle();
    set_op(2'd0, 20'sd1, 32'sd100);
    set_op(2'd1, 20'sd2, 32'sd200);
    set_op(2'd2, 20'sd3, 32'sd300);
    set_op(2'd3, 20'sd4, 32'sd400);
    for (int c = 0; c < 10; c++) begin
      req_valid = (c < 8) ? 4'b1111 : 4'b0000;
      er = (c < 8) ? (4'b0001 << (c % 4)) : 4'b0000;
      ev = (c >= 2) ? (4'b0001 << ((c - 2) % 4)) : 4'b0000;
      ed = (c >= 2) ? 32'(101 * (((c - 2) % 4) + 1)) : 32'h0;
      sample($sformatf("rr.c%0d", c), er, ev, ed, c >= 1);
      next_cycle();
    end
    req_valid = 4'b0000;
    sample("rr.c10", 4'b0000, 4'b0000, 32'h0, 1'b0);
    next_cycle();

    // Wrap on overflow (the pointer is at 0 here)
    set_op(2'd0, 20'sd1, 32'sh7FFF_FFFF);
    req_valid = 4'b0001;
    sample("ovf.c0", 4'b0001, 4'b0000, 32'h0, 1'b0);
    next_cycle();
    set_op(2'd1, -20'sd1, 32'sd0);
    req_valid = 4'b0010;
    sample("ovf.c1", 4'b0010, 4'b0000, 32'h0, 1'b1);
    next_cycle();
    req_valid = 4'b0000;
    sample("ovf.c2", 4'b0000, 4'b0001, 32'h8000_0000, 1'b1);
    next_cycle();
    sample("ovf.c3", 4'b0000, 4'b0010, 32'hFFFF_FFFF, 1'b1);
    next_cycle();
    sample("ovf.c4", 4'b0000, 4'b0000, 32'h0, 1'b0);
    next_cycle();

    // Pointer skip with ptr = 2 and only requesters 1 and 3 valid
    set_op(2'd1, -20'sd3, -32'sd4);
    set_op(2'd3, 20'sd1000, -32'sd1);
    for (int c = 0; c < 7; c++) begin
      req_valid = (c < 4) ? 4'b1010 : 4'b0000;
      er = (c < 4) ? ((c % 2 == 0) ? 4'b1000 : 4'b0010) : 4'b0000;
      ev = (c >= 2 && c < 6) ? ((c % 2 == 0) ? 4'b1000 : 4'b0010) : 4'b0000;
      ed = (c % 2 == 0) ? 32'd999 : 32'hFFFF_FFF9;
      sample($sformatf("skip.c%0d", c), er, ev, ed, (c >= 1) && (c < 6));
      next_cycle();
    end

    // Stall for 3 cycles with two requests in flight (ptr = 2)
    set_op(2'd2, 20'sd7, 32'sd8);
    req_valid = 4'b0100;
    sample("stall.c0", 4'b0100, 4'b0000, 32'h0, 1'b0);
    next_cycle();
    set_op(2'd0, -20'sd10, 32'sd3);
    req_valid = 4'b0001;
    sample("stall.c1", 4'b0001, 4'b0000, 32'h0, 1'b1);
    next_cycle();
    enable    = 1'b0;
    req_valid = 4'b1111;
    for (int c = 2; c < 5; c++) begin
      sample($sformatf("stall.c%0d", c), 4'b0000, 4'b0000, 32'h0, 1'b1);
      next_cycle();
    end
    enable    = 1'b1;
    req_valid = 4'b0000;
    sample("stall.c5", 4'b0000, 4'b0100, 32'd15, 1'b1);
    next_cycle();
    sample("stall.c6", 4'b0000, 4'b0001, 32'hFFFF_FFF9, 1'b1);
    next_cycle();
    sample("stall.c7", 4'b0000, 4'b0000, 32'h0, 1'b0);
    next_cycle();

    // Asynchronous reset with two requests in flight (ptr = 1)
    set_op(2'd1, 20'sd50, 32'sd50);
    req_valid = 4'b0010;
    sample("arst.c0", 4'b0010, 4'b0000, 32'h0, 1'b0);
    next_cycle();
    req_valid = 4'b0001;
    sample("arst.c1", 4'b0001, 4'b0000, 32'h0, 1'b1);
    next_cycle();
    req_valid = 4'b0000;
    #1;
    reset = 1'b1;
    #1;
    check("arst.now.rsp_valid", 32'(rsp_valid), 32'h0);
    check("arst.now.busy", 32'(busy), 32'h0);
    reset = 1'b0;
    sample("arst.c2", 4'b0000, 4'b0000, 32'h0, 1'b0);
    next_cycle();
    sample("arst.c3", 4'b0000, 4'b0000, 32'h0, 1'b0);
    next_cycle();
    sample("arst.c4", 4'b0000, 4'b0000, 32'h0, 1'b0);
    next_cycle();
    req_valid = 4'b1111;
    sample("arst.c5", 4'b0001, 4'b0000, 32'h0, 1'b0);
    next_cycle();
    req_valid = 4'b0000;
    sample("arst.c6", 4'b0000, 4'b0000, 32'h0, 1'b1);
    next_cycle();
    sample("arst.c7", 4'b0000, 4'b0001, 32'hFFFF_FFF9, 1'b1);
    next_cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
